// File: rtl/irq_dispatcher.sv
// rtl/irq_dispatcher.sv - latches priority-encoder winner and runs req/ack/done service handshake
// Optional per-channel service counters: define IRQ_DISPATCH_STATS_EN.
module irq_dispatcher #(
  parameter int ACK_TIMEOUT = 15,
  parameter int HOLDOFF     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Code,
  input  logic       Valid,
  output logic       IrqReq,
  output logic [1:0] IrqId,
  input  logic       IrqAck,
  input  logic       IrqDone,
  output logic       Busy,
  output logic       TimeoutErr,
  input  logic       ClearErr,
  input  logic [1:0] StatSel,
  output logic [7:0] StatCount
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE, S_HOLD} state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [8:0] LP_HOLDOFF   = 9'(HOLDOFF);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] r_hold_cnt;
  logic [1:0] r_irq_id;
  logic       r_timeout_err;
  logic       w_ack_ok;
  logic       w_timeout;
  logic       w_hold_done;

  assign w_ack_ok    = (r_state == S_REQ) && IrqAck;
  // Ack in the final wait cycle pre-empts the timeout.
  assign w_timeout   = (r_state == S_REQ) && !IrqAck && (r_wait_cnt == LP_WAIT_LAST);
  // HOLDOFF of 0 or 1 both give a single HOLD cycle.
  assign w_hold_done = ({1'b0, r_hold_cnt} + 9'd1) >= LP_HOLDOFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (Valid) w_next = S_REQ;
      S_REQ:     if (w_ack_ok) w_next = S_SERVICE;
                 else if (w_timeout) w_next = S_HOLD;
      S_SERVICE: if (IrqDone) w_next = S_HOLD;
      S_HOLD:    if (w_hold_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    IrqReq     = (r_state == S_REQ);
    Busy       = (r_state != S_IDLE);
    IrqId      = r_irq_id;
    TimeoutErr = r_timeout_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_id      <= 2'd0;
      r_wait_cnt    <= 8'd0;
      r_hold_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && Valid) r_irq_id <= Code;
      r_wait_cnt <= (r_state == S_REQ && w_next == S_REQ) ? r_wait_cnt + 8'd1 : 8'd0;
      r_hold_cnt <= (r_state == S_HOLD && w_next == S_HOLD) ? r_hold_cnt + 8'd1 : 8'd0;
      if (w_timeout) r_timeout_err <= 1'b1;
      else if (ClearErr) r_timeout_err <= 1'b0;
    end
  end

`ifdef IRQ_DISPATCH_STATS_EN
  logic [7:0] r_stat_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_stat_cnt[i] <= 8'd0;
    end else if (w_ack_ok && r_stat_cnt[r_irq_id] != 8'hFF) begin
      r_stat_cnt[r_irq_id] <= r_stat_cnt[r_irq_id] + 8'd1;
    end
  end

  assign StatCount = r_stat_cnt[StatSel];
`else
  logic w_unused_statsel;
  assign w_unused_statsel = ^StatSel;
  assign StatCount        = 8'd0;
`endif

endmodule

// File: tb/tb_irq_dispatcher.sv
// tb/tb_irq_dispatcher.sv - directed self-checking bench for irq_dispatcher
module tb_irq_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Code;
  logic       Valid;
  logic       IrqReq;
  logic [1:0] IrqId;
  logic       IrqAck;
  logic       IrqDone;
  logic       Busy;
  logic       TimeoutErr;
  logic       ClearErr;
  logic [1:0] StatSel;
  logic [7:0] StatCount;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] id_q [$];

  irq_dispatcher #(.ACK_TIMEOUT(15), .HOLDOFF(2)) dut (
    .clk(clk), .rst_n(rst_n), .Code(Code), .Valid(Valid),
    .IrqReq(IrqReq), .IrqId(IrqId), .IrqAck(IrqAck), .IrqDone(IrqDone),
    .Busy(Busy), .TimeoutErr(TimeoutErr), .ClearErr(ClearErr),
    .StatSel(StatSel), .StatCount(StatCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one Valid edge from IDLE and checks the 1-cycle request latency.
  task automatic dispatch(input logic [1:0] code);
    logic [1:0] exp_id;
    Valid = 1'b1;
    Code  = code;
    id_q.push_back(code);
    step();
    Valid = 1'b0;
    exp_id = id_q.pop_front();
    chk("req_latency", IrqReq, 1);
    chk("irq_id", IrqId, exp_id);
  endtask

  task automatic ack_done();
    IrqAck = 1'b1;
    step();
    IrqAck  = 1'b0;
    IrqDone = 1'b1;
    step();
    IrqDone = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [1:0] exp_id;
    rst_n = 1'b0; Code = 2'd0; Valid = 1'b0; IrqAck = 1'b0; IrqDone = 1'b0;
    ClearErr = 1'b0; StatSel = 2'd0;
    #12;
    chk("rst_req", IrqReq, 0);
    chk("rst_id", IrqId, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err", TimeoutErr, 0);
    chk("rst_stat", StatCount, 0);
    rst_n = 1'b1;
    step();

    // Basic dispatch, then a new request held during service.
    dispatch(2'd2);
    chk("busy_req", Busy, 1);
    Valid = 1'b1;
    Code  = 2'd3;
    step();
    chk("id_hold_req", IrqId, 2);
    IrqAck = 1'b1;
    step();
    IrqAck = 1'b0;
    chk("svc_req_low", IrqReq, 0);
    chk("svc_busy", Busy, 1);
    step();
    chk("id_hold_svc", IrqId, 2);
    IrqDone = 1'b1;
    step();
    IrqDone = 1'b0;
    chk("hold_busy1", Busy, 1);
    chk("hold_req", IrqReq, 0);
    step();
    chk("hold_busy2", Busy, 1);
    step();
    chk("idle_busy", Busy, 0);
    chk("idle_id_kept", IrqId, 2);
    id_q.push_back(2'd3);
    step();
    Valid = 1'b0;
    exp_id = id_q.pop_front();
    chk("redispatch_req", IrqReq, 1);
    chk("redispatch_id", IrqId, exp_id);

    // Timeout: request high for exactly 15 cycles.
    for (int i = 0; i < 14; i++) begin
      step();
      chk("to_req_high", IrqReq, 1);
      chk("to_err_low", TimeoutErr, 0);
    end
    step();
    chk("to_req_fall", IrqReq, 0);
    chk("to_err_set", TimeoutErr, 1);
    chk("to_busy_hold", Busy, 1);
    step();
    step();
    chk("to_idle", Busy, 0);
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    chk("clear_err", TimeoutErr, 0);

    // ClearErr coincident with a fresh timeout.
    dispatch(2'd1);
    for (int i = 0; i < 13; i++) step();
    ClearErr = 1'b1;
    step();
    chk("pre_to_req", IrqReq, 1);
    step();
    ClearErr = 1'b0;
    chk("set_wins", TimeoutErr, 1);
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    step();
    chk("clear_in_hold", TimeoutErr, 0);
    chk("idle_again", Busy, 0);

    // Ack in the final wait cycle beats the timeout.
    dispatch(2'd3);
    for (int i = 0; i < 14; i++) step();
    chk("last_wait_req", IrqReq, 1);
    IrqAck = 1'b1;
    step();
    IrqAck = 1'b0;
    chk("ack_last_req", IrqReq, 0);
    chk("ack_last_err", TimeoutErr, 0);
    step();
    step();
    chk("ack_last_svc", Busy, 1);

    // Asynchronous reset mid-service.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", IrqReq, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_id", IrqId, 0);
    chk("arst_err", TimeoutErr, 0);
    step();
    rst_n = 1'b1;
    step();
    dispatch(2'd1);
    ack_done();
    chk("post_rst_idle", Busy, 0);

`ifdef IRQ_DISPATCH_STATS_EN
    for (int i = 0; i < 300; i++) begin
      Valid = 1'b1;
      Code  = 2'd1;
      step();
      Valid = 1'b0;
      ack_done();
    end
    StatSel = 2'd1;
    #1;
    chk("stat_sat", StatCount, 8'd255);
    StatSel = 2'd0;
    #1;
    chk("stat_ch0", StatCount, 8'd0);
`else
    for (int s = 0; s < 4; s++) begin
      StatSel = 2'(s);
      #1;
      chk("stat_tied", StatCount, 8'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
